// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic/shift ops plus an iterative
// shift-add multiplier, with valid/ready handshakes on both sides.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t state, state_nxt;

  logic accept, mul_step;

  logic signed [WIDTH:0] s_sum, s_dif;
  logic [WIDTH-1:0]      alu_res;
  logic                  alu_c, alu_v;

  logic [2*WIDTH-1:0] acc, mcand, acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     cnt;

  function automatic logic [3:0] pack_flags(input logic c, input logic v,
                                            input logic [WIDTH-1:0] r);
    return {c, v, r[WIDTH-1], (r == '0)};
  endfunction

  // Any amount bit at or above SHW means the amount is >= WIDTH.
  function automatic logic [WIDTH-1:0] shift_op(input logic left,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] amt);
    if (|amt[WIDTH-1:SHW]) return '0;
    return left ? (x << amt[SHW-1:0]) : (x >> amt[SHW-1:0]);
  endfunction

  // Sign-extended sums give overflow directly; unsigned carry comes from wraparound.
  always_comb begin
    s_sum   = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
    s_dif   = $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = s_sum[WIDTH-1:0];
        alu_c   = (s_sum[WIDTH-1:0] < a);
        alu_v   = s_sum[WIDTH] ^ s_sum[WIDTH-1];
      end
      OP_SUB: begin
        alu_res = s_dif[WIDTH-1:0];
        alu_c   = (a < b);
        alu_v   = s_dif[WIDTH] ^ s_dif[WIDTH-1];
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SHL:  alu_res = shift_op(1'b1, a, b);
      OP_SHR:  alu_res = shift_op(1'b0, a, b);
      default: alu_res = '0;
    endcase
  end

  assign acc_nxt = mplier[0] ? (acc + mcand) : acc;
  assign accept  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = (op == OP_MUL) ? MUL : DONE;
      MUL:  if (&cnt) state_nxt = DONE;
      DONE: if (out_ready) begin
        if (!in_valid)           state_nxt = IDLE;
        else if (op == OP_MUL)   state_nxt = MUL;
        else                     state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid = (state == DONE);
    mul_step  = (state == MUL);
  end

  // Result registers only move on accept or at the last multiply step, so
  // they stay put while a result waits in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out    <= '0;
      flags  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept) begin
      if (op == OP_MUL) begin
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        cnt    <= '0;
      end else begin
        out   <= alu_res;
        flags <= pack_flags(alu_c, alu_v, alu_res);
      end
    end else if (mul_step) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (&cnt) begin
        out   <= acc_nxt[WIDTH-1:0];
        flags <= pack_flags(|acc_nxt[2*WIDTH-1:WIDTH], 1'b0, acc_nxt[WIDTH-1:0]);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8: directed cases, random ops,
// backpressure with back-to-back accept, and asynchronous reset mid-multiply.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]   op;
  logic [W-1:0] a, b, out;
  logic [3:0]   flags;

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   flg;
  } exp_t;

  exp_t sb[$];
  int   tests, fails;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .flags(flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Independent reference model using integer arithmetic.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int   ux, uy, sx, sy, r, sr;
    logic c, v;
    exp_t e;
    ux = x; uy = y; sx = $signed(x); sy = $signed(y);
    c = 1'b0; v = 1'b0; r = 0;
    case (o)
      3'd0: begin r = ux + uy; c = (r > 255); sr = sx + sy; v = (sr > 127) || (sr < -128); end
      3'd1: begin r = ux - uy; c = (ux < uy); sr = sx - sy; v = (sr > 127) || (sr < -128); end
      3'd2: r = ux & uy;
      3'd3: r = ux | uy;
      3'd4: r = ux ^ uy;
      3'd5: r = (uy >= W) ? 0 : (ux << uy);
      3'd6: r = (uy >= W) ? 0 : (ux >> uy);
      default: begin r = ux * uy; c = (r > 255); end
    endcase
    e.res = r[W-1:0];
    e.flg = {c, v, e.res[W-1], (e.res == '0)};
    return e;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output bit ok);
    ok = 1'b0;
    in_valid = 1'b1; op = o; a = x; b = y;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) sb.push_back(model(o, x, y));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid; lat counts the accept edge as cycle 1.
  task automatic collect(output logic [W-1:0] ro, output logic [3:0] rf, output exp_t e,
                         output int lat, output bit rdy_seen);
    lat = 1; rdy_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    ro = out; rf = flags;
    if (sb.size() > 0) e = sb.pop_front();
    else e = '1;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (out !== 8'h00) begin fails++; $display("FAIL reset_out: got %h want 00", out); end
    tests++; if (flags !== 4'b0000) begin fails++; $display("FAIL reset_flags: got %b want 0000", flags); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add_sub();
    bit ok, rs; int lat; logic [W-1:0] ro; logic [3:0] rf; exp_t e;
    issue(3'd0, 8'd200, 8'd100, ok);
    collect(ro, rf, e, lat, rs);
    tests++; if (lat !== 1) begin fails++; $display("FAIL add_latency: got %0d want 1", lat); end
    tests++; if (ro !== 8'h2C || rf !== 4'b1000 || {ro, rf} !== {e.res, e.flg})
      begin fails++; $display("FAIL add_carry: got %h/%b want 2c/1000", ro, rf); end
    retire();
    issue(3'd0, 8'h7F, 8'h01, ok);
    collect(ro, rf, e, lat, rs);
    tests++; if (ro !== 8'h80 || rf !== 4'b0110 || {ro, rf} !== {e.res, e.flg})
      begin fails++; $display("FAIL add_overflow: got %h/%b want 80/0110", ro, rf); end
    retire();
    issue(3'd1, 8'd5, 8'd10, ok);
    collect(ro, rf, e, lat, rs);
    tests++; if (ro !== 8'hFB || rf !== 4'b1010 || {ro, rf} !== {e.res, e.flg})
      begin fails++; $display("FAIL sub_borrow: got %h/%b want fb/1010", ro, rf); end
    retire();
  endtask

  task automatic test_mul();
    bit ok, rs; int lat; logic [W-1:0] ro; logic [3:0] rf; exp_t e;
    issue(3'd7, 8'd15, 8'd17, ok);
    collect(ro, rf, e, lat, rs);
    tests++; if (lat !== 9) begin fails++; $display("FAIL mul_latency: got %0d want 9", lat); end
    tests++; if (rs !== 1'b0) begin fails++; $display("FAIL mul_in_ready: got in_ready high during MUL, want low"); end
    tests++; if (ro !== 8'hFF || rf !== 4'b0010 || {ro, rf} !== {e.res, e.flg})
      begin fails++; $display("FAIL mul_15x17: got %h/%b want ff/0010", ro, rf); end
    retire();
    issue(3'd7, 8'd16, 8'd16, ok);
    in_valid = 1'b1; op = 3'd0; a = 8'd1; b = 8'd1;
    collect(ro, rf, e, lat, rs);
    in_valid = 1'b0;
    tests++; if (lat !== 9 || rs !== 1'b0) begin fails++; $display("FAIL mul_ignore_in: got lat %0d rdy %b want 9/0", lat, rs); end
    tests++; if (ro !== 8'h00 || rf !== 4'b1001 || {ro, rf} !== {e.res, e.flg})
      begin fails++; $display("FAIL mul_16x16: got %h/%b want 00/1001", ro, rf); end
    retire();
  endtask

  task automatic test_shift();
    bit ok, rs; int lat; logic [W-1:0] ro; logic [3:0] rf; exp_t e;
    issue(3'd5, 8'h81, 8'd1, ok);
    collect(ro, rf, e, lat, rs);
    tests++; if (ro !== 8'h02 || rf !== 4'b0000 || {ro, rf} !== {e.res, e.flg})
      begin fails++; $display("FAIL shl: got %h/%b want 02/0000", ro, rf); end
    retire();
    issue(3'd6, 8'h80, 8'd9, ok);
    collect(ro, rf, e, lat, rs);
    tests++; if (ro !== 8'h00 || rf !== 4'b0001 || {ro, rf} !== {e.res, e.flg})
      begin fails++; $display("FAIL shr_big: got %h/%b want 00/0001", ro, rf); end
    retire();
  endtask

  task automatic test_random();
    bit ok, rs; int lat, want_lat; logic [W-1:0] ro, x, y; logic [3:0] rf; exp_t e; logic [2:0] o;
    for (int i = 0; i < 32; i++) begin
      o = 3'($urandom_range(0, 7));
      x = 8'($urandom);
      y = (o == 3'd5 || o == 3'd6) ? 8'($urandom_range(0, 11)) : 8'($urandom);
      want_lat = (o == 3'd7) ? 9 : 1;
      issue(o, x, y, ok);
      collect(ro, rf, e, lat, rs);
      tests++;
      if (!ok || lat !== want_lat || {ro, rf} !== {e.res, e.flg}) begin
        fails++;
        $display("FAIL random op%0d a=%h b=%h: got %h/%b lat %0d want %h/%b lat %0d",
                 o, x, y, ro, rf, lat, e.res, e.flg, want_lat);
      end
      retire();
    end
  endtask

  task automatic test_back_to_back();
    bit ok, rs; int lat; logic [W-1:0] ro; logic [3:0] rf; exp_t e;
    issue(3'd2, 8'hF0, 8'h3C, ok);
    collect(ro, rf, e, lat, rs);
    tests++; if (ro !== 8'h30 || {ro, rf} !== {e.res, e.flg}) begin fails++; $display("FAIL and: got %h/%b want 30/0000", ro, rf); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++;
      if (out !== 8'h30 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold_%0d: got out %h vld %b rdy %b want 30/1/0", i, out, out_valid, in_ready);
      end
    end
    out_ready = 1'b1; in_valid = 1'b1; op = 3'd3; a = 8'h0F; b = 8'hF0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
    sb.push_back(model(3'd3, 8'h0F, 8'hF0));
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    e = (sb.size() > 0) ? sb.pop_front() : '1;
    tests++;
    if (out_valid !== 1'b1 || out !== 8'hFF || {out, flags} !== {e.res, e.flg}) begin
      fails++;
      $display("FAIL b2b_or: got vld %b out %h/%b want 1 ff/0010", out_valid, out, flags);
    end
    retire();
  endtask

  task automatic test_async_reset();
    bit ok, rs; int lat; logic [W-1:0] ro; logic [3:0] rf; exp_t e;
    issue(3'd0, 8'h33, 8'h11, ok);
    collect(ro, rf, e, lat, rs);
    retire();
    issue(3'd7, 8'd15, 8'd17, ok);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out !== 8'h00 || flags !== 4'b0000) begin
      fails++;
      $display("FAIL async_rst: got vld %b out %h flags %b want 0/00/0000", out_valid, out, flags);
    end
    if (sb.size() > 0) void'(sb.pop_front());
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin fails++; $display("FAIL post_rst: got rdy %b vld %b want 1/0", in_ready, out_valid); end
    issue(3'd0, 8'd1, 8'd1, ok);
    collect(ro, rf, e, lat, rs);
    tests++; if (lat !== 1 || ro !== 8'h02 || rf !== 4'b0000 || {ro, rf} !== {e.res, e.flg})
      begin fails++; $display("FAIL post_rst_add: got %h/%b lat %0d want 02/0000 lat 1", ro, rf, lat); end
    retire();
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; a = '0; b = '0;
    test_reset();
    test_add_sub();
    test_mul();
    test_shift();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits; legal range 2..32, power of two.
REQ-002 SHALL have localparam SHW = log2(WIDTH), the shift-amount width.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand/op presented.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation.
REQ-007 SHALL have port op  input  3  opcode.
REQ-008 SHALL have ports a and b  input  WIDTH  operands.
REQ-009 SHALL have port out_valid  output  1  result presented.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out  output  WIDTH  result.
REQ-012 SHALL have port flags  output  4  {carry, overflow, negative, zero}, MSB first.

Function
REQ-013 SHALL accept an operation on any edge where in_valid and in_ready are both 1, capturing op, a and b.
REQ-014 SHALL decode opcodes: 000 a+b; 001 a-b; 010 a&b; 011 a|b; 100 a^b; 101 a<<b; 110 a>>b (logical); 111 a*b (low WIDTH bits).
REQ-015 SHALL implement shifts where b >= WIDTH as a result of 0; otherwise the shift amount is b[SHW-1:0].
REQ-016 SHALL use FSM states IDLE, MUL and DONE.
REQ-017 SHALL move IDLE->DONE on acceptance of opcodes 000-110, with result and flags registered on the same edge.
REQ-018 SHALL move IDLE->MUL on acceptance of 111 and perform iterative shift-add over exactly WIDTH cycles; MUL->DONE on the WIDTH-th cycle.
REQ-019 SHALL give a latency from the accept edge to out_valid high of 1 cycle for single-cycle ops and WIDTH+1 cycles for MUL.
REQ-020 SHALL hold out_valid high in DONE; out and flags SHALL stay stable until the out_valid&&out_ready edge.
REQ-021 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready).
REQ-022 SHALL, on a DONE edge with out_ready and in_valid both high, retire the current result and accept the new op on the same edge (back-to-back); with in_valid low it SHALL return to IDLE.
REQ-023 SHALL hold in_ready low throughout MUL; in_valid in MUL SHALL be ignored.
REQ-024 SHALL set zero = (out==0) and negative = out[WIDTH-1] for all ops.
REQ-025 SHALL set carry to the unsigned carry-out for ADD and the borrow (a<b unsigned) for SUB.
REQ-026 SHALL set carry for MUL = 1 when product bits [2*WIDTH-1:WIDTH] are nonzero; carry SHALL be 0 for all other ops.
REQ-027 SHALL set overflow to signed two's-complement overflow for ADD and SUB; overflow SHALL be 0 for all other ops.
REQ-028 SHALL ignore out_ready when out_valid is low.

Reset
REQ-029 SHALL, while rst is high, force state=IDLE, out_valid=0, out=0, flags=0 and clear the MUL accumulator/counter, independent of clk.
REQ-030 SHALL abandon any operation in flight at reset mid-operation, with no result delivered.
REQ-031 SHALL assert in_ready on the first cycle after rst deasserts.

Verification (WIDTH=8)
REQ-032 SHALL be verified by: ADD a=200, b=100 -> next cycle out=0x2C, carry=1, overflow=0, zero=0, negative=0.
REQ-033 SHALL be verified by: ADD 0x7F+0x01 -> out=0x80, overflow=1, negative=1, carry=0; SUB 5-10 -> out=0xFB, carry=1, negative=1, overflow=0.
REQ-034 SHALL be verified by: MUL 15*17 -> out_valid exactly 9 cycles after accept, out=0xFF, carry=0; MUL 16*16 -> out=0x00, zero=1, carry=1; in_ready=0 throughout MUL.
REQ-035 SHALL be verified by: SHL a=0x81, b=1 -> out=0x02; SHR a=0x80, b=9 -> out=0x00, zero=1.
REQ-036 SHALL be verified by: out_ready held low 3 cycles after AND 0xF0&0x3C -> out=0x30 stable, in_ready=0; then out_ready=1 with in_valid=1 (OR 0x0F|0xF0) -> same-edge accept, next cycle out=0xFF.
REQ-037 SHALL be verified by: rst pulsed asynchronously (not clock-aligned) 4 cycles into a MUL -> out_valid=0 and out=0 immediately; next cycle after release in_ready=1; a following ADD 1+1 -> out=0x02.
